writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 160 ++++++++++++++++
 tb/tb_writeback_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: aligns load data, selects the result and drives the register file.
// Loads without an acknowledge park the pipe in WAIT until memory answers.
module writeback_stage (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en,
    input  logic [19:0] inst_u_imm_in,
    input  logic [2:0]  inst_fn3_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [2:0]  ctr_in,
    input  logic [31:0] alu_in,
    input  logic [29:0] inc_pc_in,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ack,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] retire_count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_rd;
    logic [2:0]  r_fn3;
    logic [1:0]  r_off;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_retire_count;

    logic        w_is_load;
    logic [2:0]  w_ld_fn3;
    logic [1:0]  w_ld_off;
    logic [7:0]  w_byte [4];
    logic [7:0]  w_b_sel;
    logic [15:0] w_h_sel;
    logic [31:0] w_ld_data;
    logic [31:0] w_nl_data;
    logic        w_done;
    logic [4:0]  w_dst;
    logic [31:0] w_data;
    logic        w_stall;
    logic        w_write;

    assign w_is_load = ctr_in[0];

    // In WAIT the instruction has left the inputs; only the captured fields apply.
    assign w_ld_fn3 = (r_state == S_WAIT) ? r_fn3 : inst_fn3_in;
    assign w_ld_off = (r_state == S_WAIT) ? r_off : alu_in[1:0];

    // Big-endian lanes: offset 0 lives in the top byte.
    assign w_byte[0] = mem_data_in[31:24];
    assign w_byte[1] = mem_data_in[23:16];
    assign w_byte[2] = mem_data_in[15:8];
    assign w_byte[3] = mem_data_in[7:0];

    assign w_b_sel = w_byte[w_ld_off];
    assign w_h_sel = w_ld_off[1] ? {w_byte[3], w_byte[2]}
                                 : {w_byte[1], w_byte[0]};

    always_comb begin
        w_ld_data = 32'h0;
        case (w_ld_fn3)
            3'd0:    w_ld_data = {{24{w_b_sel[7]}}, w_b_sel};
            3'd4:    w_ld_data = {24'h0, w_b_sel};
            3'd1:    w_ld_data = {{16{w_h_sel[15]}}, w_h_sel};
            3'd5:    w_ld_data = {16'h0, w_h_sel};
            3'd2:    w_ld_data = {w_byte[3], w_byte[2],
                                  w_byte[1], w_byte[0]};
            default: w_ld_data = 32'h0;
        endcase
    end

    always_comb begin
        w_nl_data = 32'h0;
        case (ctr_in[2:1])
            2'b01:   w_nl_data = alu_in;
            2'b10:   w_nl_data = {inc_pc_in, 2'b00};
            2'b11:   w_nl_data = {inst_u_imm_in, 12'h000};
            default: w_nl_data = 32'h0;
        endcase
    end

    always_comb begin
        w_done  = 1'b0;
        w_dst   = rd_addr_in;
        w_data  = w_nl_data;
        w_stall = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                w_done  = mem_ack;
                w_dst   = r_rd;
                w_data  = w_ld_data;
                w_stall = !mem_ack;
            end
            S_RUN: begin
                if (w_is_load) begin
                    w_done  = mem_ack;
                    w_data  = w_ld_data;
                    w_stall = !mem_ack;
                end else begin
                    w_done  = (ctr_in[2:1] != 2'b00);
                end
            end
        endcase
    end

    assign w_write = w_done && (w_dst != 5'd0);

    // Reset forces the hold request low even if a missing load is presented.
    assign stall = async_rst_n & w_stall;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state        <= S_RUN;
            r_rd           <= 5'd0;
            r_fn3          <= 3'd0;
            r_off          <= 2'd0;
            r_we           <= 1'b0;
            r_waddr        <= 5'd0;
            r_wdata        <= 32'h0;
            r_retire_count <= 32'h0;
        end else if (clk_en) begin
            r_we <= w_write;
            if (w_write) begin
                r_waddr <= w_dst;
                r_wdata <= w_data;
            end
            if (w_done) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
            unique case (r_state)
                S_RUN: begin
                    if (w_is_load && !mem_ack) begin
                        r_state <= S_WAIT;
                        r_rd    <= rd_addr_in;
                        r_fn3   <= inst_fn3_in;
                        r_off   <= alu_in[1:0];
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_state <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign rf_we        = r_we;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed cases then random instructions
// checked against an arithmetic model of the writeback rules.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en;
    logic [19:0] inst_u_imm_in;
    logic [2:0]  inst_fn3_in;
    logic [4:0]  rd_addr_in;
    logic [2:0]  ctr_in;
    logic [31:0] alu_in;
    logic [29:0] inc_pc_in;
    logic [31:0] mem_data_in;
    logic        mem_ack;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retire_count;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_retire;

    writeback_stage dut (
        .clk           (clk),
        .async_rst_n   (async_rst_n),
        .clk_en        (clk_en),
        .inst_u_imm_in (inst_u_imm_in),
        .inst_fn3_in   (inst_fn3_in),
        .rd_addr_in    (rd_addr_in),
        .ctr_in        (ctr_in),
        .alu_in        (alu_in),
        .inc_pc_in     (inc_pc_in),
        .mem_data_in   (mem_data_in),
        .mem_ack       (mem_ack),
        .stall         (stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte k of the memory word, offset 0 being the most significant lane.
    function automatic int unsigned mbyte(input logic [31:0] d, input int k);
        return (int'(d) >>> 0) >= 0 ? ((d >> (8 * (3 - k))) & 32'hFF)
                                    : ((d >> (8 * (3 - k))) & 32'hFF);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] ctr,
                                          input logic [2:0] fn3,
                                          input logic [31:0] alu,
                                          input logic [29:0] pc,
                                          input logic [19:0] imm,
                                          input logic [31:0] data);
        int unsigned off, v;
        off = alu % 4;
        if (ctr[0]) begin
            case (fn3)
                3'd0, 3'd4: begin
                    v = mbyte(data, off);
                    if (fn3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
                end
                3'd1, 3'd5: begin
                    v = (off >= 2) ? mbyte(data, 3) * 256 + mbyte(data, 2)
                                   : mbyte(data, 1) * 256 + mbyte(data, 0);
                    if (fn3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
                end
                3'd2: v = mbyte(data, 3) * 32'd16777216 +
                          mbyte(data, 2) * 32'd65536 +
                          mbyte(data, 1) * 32'd256 + mbyte(data, 0);
                default: v = 0;
            endcase
        end else begin
            case (ctr[2:1])
                2'b01:   v = alu;
                2'b10:   v = 32'(pc) * 4;
                2'b11:   v = 32'(imm) * 4096;
                default: v = 0;
            endcase
        end
        return v;
    endfunction

    // Present one instruction; a load waits wait_n cycles for its acknowledge.
    task automatic issue(input logic [2:0] ctr, input logic [4:0] rd,
                         input logic [2:0] fn3, input logic [31:0] alu,
                         input logic [29:0] pc, input logic [19:0] imm,
                         input logic [31:0] data, input int wait_n);
        logic        retires;
        logic        writes;
        logic        held;
        logic [31:0] exp_d;
        retires = (ctr != 3'b000);
        writes  = retires && (rd != 5'd0);
        held    = ctr[0] && (wait_n > 0);
        exp_d   = model(ctr, fn3, alu, pc, imm, data);
        ctr_in        = ctr;
        rd_addr_in    = rd;
        inst_fn3_in   = fn3;
        alu_in        = alu;
        inc_pc_in     = pc;
        inst_u_imm_in = imm;
        mem_data_in   = held ? $urandom : data;
        mem_ack       = ctr[0] ? !held : 1'($urandom);
        #1;
        chk("stall_first", stall, held);
        for (int k = 0; held && k < wait_n; k++) begin
            @(posedge clk);
            #1;
            chk("we_waiting", rf_we, 1'b0);
            chk("retire_waiting", retire_count, exp_retire);
            rd_addr_in  = $urandom;
            inst_fn3_in = $urandom;
            alu_in      = $urandom;
            mem_ack     = (k == wait_n - 1);
            mem_data_in = mem_ack ? data : $urandom;
            #1;
            chk("stall_wait", stall, !mem_ack);
        end
        @(posedge clk);
        #1;
        if (retires) exp_retire = exp_retire + 32'd1;
        chk("we", rf_we, writes);
        if (writes) begin
            chk("waddr", rf_waddr, rd);
            chk("wdata", rf_wdata, exp_d);
        end
        chk("retire", retire_count, exp_retire);
    endtask

    initial begin
        async_rst_n   = 1'b0;
        clk_en        = 1'b1;
        inst_u_imm_in = '0;
        inst_fn3_in   = '0;
        rd_addr_in    = '0;
        ctr_in        = 3'b001;
        alu_in        = '0;
        inc_pc_in     = '0;
        mem_data_in   = '0;
        mem_ack       = 1'b0;
        exp_retire    = 32'h0;
        #12;
        chk("rst_stall", stall, 1'b0);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_retire", retire_count, 32'h0);
        ctr_in = 3'b000;
        @(negedge clk);
        async_rst_n = 1'b1;

        issue(3'b010, 5'd5, 3'd0, 32'h1234_5678, 30'd0, 20'd0, 32'd0, 0);
        chk("alu_wdata", rf_wdata, 32'h1234_5678);
        chk("alu_retire", retire_count, 32'd1);
        issue(3'b000, 5'd6, 3'd0, 32'h0, 30'd0, 20'd0, 32'd0, 0);

        issue(3'b001, 5'd3, 3'd0, 32'h0000_1001, 30'd0, 20'd0, 32'h1185_3344, 0);
        chk("lb_const", rf_wdata, 32'hFFFF_FF85);
        issue(3'b001, 5'd3, 3'd4, 32'h0000_1001, 30'd0, 20'd0, 32'h1185_3344, 0);
        chk("lbu_const", rf_wdata, 32'h0000_0085);
        issue(3'b001, 5'd4, 3'd1, 32'h0000_2002, 30'd0, 20'd0, 32'h1122_3344, 0);
        chk("lh_const", rf_wdata, 32'h0000_4433);
        issue(3'b001, 5'd4, 3'd2, 32'h0000_2000, 30'd0, 20'd0, 32'h1122_3344, 0);
        chk("lw_const", rf_wdata, 32'h4433_2211);

        issue(3'b001, 5'd7, 3'd2, 32'h0000_0000, 30'd0, 20'd0, 32'hCAFE_F00D, 3);
        chk("wait_waddr", rf_waddr, 5'd7);
        issue(3'b000, 5'd7, 3'd0, 32'h0, 30'd0, 20'd0, 32'd0, 0);

        issue(3'b110, 5'd0, 3'd0, 32'h0, 30'd0, 20'hABCDE, 32'd0, 0);
        issue(3'b100, 5'd9, 3'd0, 32'h0, 30'h0000_0401, 20'd0, 32'd0, 0);
        chk("link_const", rf_wdata, 32'h0000_1004);

        // Enable low: everything holds, stall still reacts.
        clk_en     = 1'b0;
        ctr_in     = 3'b010;
        rd_addr_in = 5'd4;
        alu_in     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("hold_we", rf_we, 1'b1);
        chk("hold_waddr", rf_waddr, 5'd9);
        chk("hold_wdata", rf_wdata, 32'h0000_1004);
        chk("hold_retire", retire_count, exp_retire);
        ctr_in  = 3'b001;
        mem_ack = 1'b0;
        #1;
        chk("hold_stall", stall, 1'b1);
        clk_en = 1'b1;
        issue(3'b000, 5'd0, 3'd0, 32'h0, 30'd0, 20'd0, 32'd0, 0);

        // Enable low while waiting: acknowledge is not consumed.
        issue(3'b001, 5'd12, 3'd5, 32'h0000_0002, 30'd0, 20'd0, 32'h0, 1);
        ctr_in      = 3'b001;
        rd_addr_in  = 5'd12;
        inst_fn3_in = 3'd2;
        alu_in      = 32'h0;
        mem_ack     = 1'b0;
        @(posedge clk);
        #1;
        clk_en      = 1'b0;
        mem_ack     = 1'b1;
        mem_data_in = 32'h0102_0304;
        #1;
        chk("en_wait_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("en_wait_we", rf_we, 1'b0);
        chk("en_wait_retire", retire_count, exp_retire);
        mem_ack = 1'b0;
        #1;
        chk("en_wait_still", stall, 1'b1);
        clk_en  = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        exp_retire = exp_retire + 32'd1;
        chk("en_wait_wr", rf_we, 1'b1);
        chk("en_wait_addr", rf_waddr, 5'd12);
        chk("en_wait_data", rf_wdata, 32'h0403_0201);

        // Counter wrap.
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        exp_retire = 32'hFFFF_FFFF;
        issue(3'b010, 5'd1, 3'd0, 32'h5555_AAAA, 30'd0, 20'd0, 32'd0, 0);
        chk("wrap", retire_count, 32'h0);

        // Reset while waiting abandons the load.
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        ctr_in      = 3'b001;
        rd_addr_in  = 5'd13;
        inst_fn3_in = 3'd2;
        mem_ack     = 1'b0;
        @(posedge clk);
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("wrst_stall", stall, 1'b0);
        chk("wrst_we", rf_we, 1'b0);
        chk("wrst_waddr", rf_waddr, 5'd0);
        chk("wrst_wdata", rf_wdata, 32'h0);
        chk("wrst_retire", retire_count, 32'h0);
        ctr_in = 3'b000;
        @(negedge clk);
        async_rst_n = 1'b1;
        #1;
        chk("wrst_run", stall, 1'b0);
        mem_ack     = 1'b1;
        mem_data_in = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        exp_retire = 32'h0;
        chk("wrst_nowrite", rf_we, 1'b0);
        chk("wrst_noretire", retire_count, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            issue(c,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  3'($urandom), $urandom, 30'($urandom), 20'($urandom),
                  $urandom, c[0] ? $urandom_range(0, 3) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
